// File: rtl/spiflash_rd_master.sv
// SPI flash read master: releases the flash from power-down (0xAB) after reset, then serves
// 32-bit reads (command 0x03 + 24-bit address) and returns the word byte-assembled little-endian.
module spiflash_rd_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CSB_GAP = 4
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        req,
  input  logic [23:0] addr,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0_do,
  output logic        flash_io0_oeb,
  input  logic        flash_io1_di
);

  localparam logic [2:0] StWake = 3'd0;
  localparam logic [2:0] StWgap = 3'd1;
  localparam logic [2:0] StIdle = 3'd2;
  localparam logic [2:0] StXfer = 3'd3;
  localparam logic [2:0] StGap  = 3'd4;

  logic [2:0]  state_q;
  logic        csb_q;
  logic        sck_q;
  logic [63:0] tx_q;
  logic [31:0] rx_q;
  logic [3:0]  div_q;
  logic [5:0]  bit_q;
  logic [3:0]  gap_q;
  logic        ack_q;
  logic [31:0] rdata_q;

  logic        div_done;
  logic        sck_rise;
  logic        sck_fall;
  logic        last_bit;
  logic        rx_en;
  logic        start_wake;
  logic        gap_done;
  logic [31:0] rx_next;

  always_comb begin
    div_done   = (div_q == 4'(CLK_DIV - 1));
    sck_rise   = !csb_q && div_done && !sck_q;
    sck_fall   = !csb_q && div_done && sck_q;
    last_bit   = (state_q == StXfer) ? (bit_q == 6'd63) : (bit_q == 6'd7);
    // Falls 33..64 carry read data; bit_q still holds the pre-increment count here.
    rx_en      = (state_q == StXfer) && (bit_q >= 6'd32);
    rx_next    = {rx_q[30:0], flash_io1_di};
    // WAKE is entered with csb high; the first clock after reset opens the command.
    start_wake = (state_q == StWake) && csb_q;
    gap_done   = (gap_q == 4'(CSB_GAP - 1));
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q <= StWake;
      csb_q   <= 1'b1;
      sck_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        StWake, StXfer: begin
          if (start_wake) begin
            csb_q <= 1'b0;
            sck_q <= 1'b0;
            div_q <= '0;
            bit_q <= '0;
            tx_q  <= {8'hAB, 56'h0};
          end else begin
            div_q <= div_done ? 4'd0 : div_q + 4'd1;
            if (sck_rise) begin
              sck_q <= 1'b1;
            end
            if (sck_fall) begin
              sck_q <= 1'b0;
              tx_q  <= tx_q << 1;
              bit_q <= bit_q + 6'd1;
              if (rx_en) begin
                rx_q <= rx_next;
              end
              if (last_bit) begin
                csb_q <= 1'b1;
                bit_q <= '0;
                gap_q <= '0;
                if (state_q == StXfer) begin
                  state_q <= StGap;
                  ack_q   <= 1'b1;
                  // First byte on the wire lands in the low byte.
                  rdata_q <= {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};
                end else begin
                  state_q <= StWgap;
                end
              end
            end
          end
        end
        StWgap, StGap: begin
          if (gap_done) begin
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        StIdle: begin
          if (req) begin
            state_q <= StXfer;
            csb_q   <= 1'b0;
            sck_q   <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= {8'h03, addr, 32'h0};
          end
        end
        default: begin
          state_q <= StWake;
          csb_q   <= 1'b1;
          sck_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ready         = (state_q == StIdle);
  assign ack           = ack_q;
  assign rdata         = rdata_q;
  assign flash_csb     = csb_q;
  assign flash_clk     = sck_q;
  assign flash_io0_do  = tx_q[63];
  assign flash_io0_oeb = csb_q;

endmodule

// File: tb/tb_spiflash_rd_master.sv
// Bench for spiflash_rd_master: a behavioural SPI flash per instance (CLK_DIV=2 and 1) plus
// directed and random reads checked with immediate assertions.
module tb_spiflash_rd_master;

  localparam int CsbGap = 4;
  localparam int DivA   = 2;
  localparam int DivB   = 1;
  localparam int Bound  = 5000;

  logic        clk;
  logic        rst;
  logic        req   [2];
  logic [23:0] addr  [2];
  logic        ready [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        csb   [2];
  logic        sck   [2];
  logic        mdo   [2];
  logic        oeb   [2];
  logic        miso  [2];

  // Flash model state: bytes in wire order (first byte in [31:24]).
  logic [31:0] fword    [2];
  int          rise_cnt [2];
  logic [63:0] mosi_sr  [2];
  logic        prev_sck [2];
  logic        prev_csb [2];
  int          ack_cnt  [2];

  int n_chk;
  int n_err;

  spiflash_rd_master #(.CLK_DIV(DivA), .CSB_GAP(CsbGap)) dut (
    .core_clk      (clk),
    .core_rst      (rst),
    .req           (req[0]),
    .addr          (addr[0]),
    .ready         (ready[0]),
    .ack           (ack[0]),
    .rdata         (rdata[0]),
    .flash_csb     (csb[0]),
    .flash_clk     (sck[0]),
    .flash_io0_do  (mdo[0]),
    .flash_io0_oeb (oeb[0]),
    .flash_io1_di  (miso[0])
  );

  spiflash_rd_master #(.CLK_DIV(DivB), .CSB_GAP(CsbGap)) dut_div1 (
    .core_clk      (clk),
    .core_rst      (rst),
    .req           (req[1]),
    .addr          (addr[1]),
    .ready         (ready[1]),
    .ack           (ack[1]),
    .rdata         (rdata[1]),
    .flash_csb     (csb[1]),
    .flash_clk     (sck[1]),
    .flash_io0_do  (mdo[1]),
    .flash_io0_oeb (oeb[1]),
    .flash_io1_di  (miso[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ack[0] === 1'b1) ack_cnt[0] <= ack_cnt[0] + 1;
    if (ack[1] === 1'b1) ack_cnt[1] <= ack_cnt[1] + 1;
  end

  // Mode-0 flash: counts SCK rises per select, captures MOSI, presents data for bits 33..64.
  task automatic mon_edge(input bit g);
    if (prev_csb[g] === 1'b1 && csb[g] === 1'b0) rise_cnt[g] = 0;
    if (prev_sck[g] === 1'b0 && sck[g] === 1'b1) begin
      rise_cnt[g] = rise_cnt[g] + 1;
      mosi_sr[g]  = {mosi_sr[g][62:0], mdo[g]};
      if (rise_cnt[g] >= 33 && rise_cnt[g] <= 64) miso[g] = fword[g][5'(64 - rise_cnt[g])];
      else miso[g] = 1'($urandom);
    end
    prev_sck[g] = sck[g];
    prev_csb[g] = csb[g];
  endtask

  always @(sck[0], sck[1], csb[0], csb[1]) begin
    mon_edge(1'b0);
    mon_edge(1'b1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected word: first byte received goes to the least significant byte.
  function automatic logic [31:0] exp_word(input logic [31:0] w);
    logic [7:0] b [4];
    b[0] = w[31:24];
    b[1] = w[23:16];
    b[2] = w[15:8];
    b[3] = w[7:0];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Caller releases reset just before; checks the power-up 0xAB command and the WGAP.
  task automatic check_wake(input string tag);
    int n;
    int gap;
    step();
    chk({tag, "_csb_low"}, 64'(csb[0]), 64'(0));
    chk({tag, "_ready_low"}, 64'(ready[0]), 64'(0));
    n = 0;
    while (csb[0] !== 1'b1 && n < Bound) begin
      step();
      n++;
    end
    chk({tag, "_rises"}, 64'(rise_cnt[0]), 64'(8));
    chk({tag, "_cmd"}, 64'(mosi_sr[0][7:0]), 64'(8'hAB));
    gap = 0;
    while (ready[0] !== 1'b1 && gap < Bound) begin
      step();
      gap++;
    end
    chk({tag, "_gap"}, 64'(gap), 64'(CsbGap));
  endtask

  task automatic do_read(input bit g, input logic [23:0] a, input logic [31:0] w,
                         input bit keep_req, input bit noise, input string tag);
    int n;
    int busy_ready;
    int gap;
    int extra;
    int acks0;
    int div;
    div = g ? DivB : DivA;
    n = 0;
    while (ready[g] !== 1'b1 && n < Bound) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, 64'(ready[g]), 64'(1));
    fword[g] = w;
    addr[g]  = a;
    req[g]   = 1'b1;
    acks0    = ack_cnt[g];
    step();
    chk({tag, "_c1_csb"}, 64'({csb[g], oeb[g], sck[g], mdo[g]}), 64'(0));
    if (!keep_req) req[g] = 1'b0;
    n = 1;
    busy_ready = 0;
    while (ack[g] !== 1'b1 && n < Bound) begin
      if (ready[g] !== 1'b0) busy_ready++;
      if (noise) begin
        if (n == 20) addr[g] = ~a;
        req[g] = (n % 13 < 2);
      end
      step();
      n++;
    end
    if (!keep_req) req[g] = 1'b0;
    chk({tag, "_ack_cycle"}, 64'(n), 64'(1 + 128 * div));
    chk({tag, "_rdata"}, 64'(rdata[g]), 64'(exp_word(w)));
    chk({tag, "_end_pins"}, 64'({csb[g], oeb[g], sck[g]}), 64'(3'b110));
    chk({tag, "_busy_ready"}, 64'(busy_ready), 64'(0));
    chk({tag, "_rises"}, 64'(rise_cnt[g]), 64'(64));
    chk({tag, "_mosi"}, mosi_sr[g], {8'h03, a, 32'h0});
    gap = 0;
    extra = 0;
    while (ready[g] !== 1'b1 && gap < Bound) begin
      step();
      gap++;
      if (ack[g] === 1'b1) extra++;
    end
    chk({tag, "_gap"}, 64'(gap), 64'(CsbGap));
    chk({tag, "_one_ack"}, 64'(ack_cnt[g] - acks0 + extra), 64'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acks0;
    n_chk = 0;
    n_err = 0;
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i]   = 1'b0;
      addr[i]  = '0;
      fword[i] = '0;
      miso[i]  = 1'b0;
    end
    repeat (3) step();

    chk("rst_pins", 64'({csb[0], sck[0], mdo[0], oeb[0]}), 64'(4'b1001));
    chk("rst_ready_ack", 64'({ready[0], ack[0], ready[1]}), 64'(0));
    chk("rst_rdata", 64'(rdata[0]), 64'(0));

    rst = 1'b0;
    check_wake("wake");

    do_read(1'b0, 24'h000010, 32'h1337BEEF, 1'b0, 1'b0, "rd_dir");
    chk("rd_dir_word", 64'(rdata[0]), 64'(32'hEFBE3713));

    for (int i = 0; i < 4; i++) begin
      do_read(1'b0, 24'($urandom), $urandom, 1'b0, 1'b1, "rd_rand");
    end

    // req held high: transfers run back to back, one ack each.
    do_read(1'b0, 24'($urandom), $urandom, 1'b1, 1'b0, "b2b0");
    do_read(1'b0, 24'($urandom), $urandom, 1'b1, 1'b0, "b2b1");
    do_read(1'b0, 24'($urandom), $urandom, 1'b0, 1'b0, "b2b2");

    // Reset at SCK rise 40 of a transfer.
    fword[0] = $urandom;
    addr[0]  = 24'($urandom);
    req[0]   = 1'b1;
    step();
    req[0] = 1'b0;
    acks0 = ack_cnt[0];
    n = 0;
    while (rise_cnt[0] < 40 && n < Bound) begin
      step();
      n++;
    end
    chk("mid_rise40", 64'(rise_cnt[0]), 64'(40));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_pins", 64'({csb[0], oeb[0], sck[0], mdo[0]}), 64'(4'b1100));
    chk("mid_rst_ready_ack", 64'({ready[0], ack[0]}), 64'(0));
    chk("mid_rst_rdata", 64'(rdata[0]), 64'(0));
    repeat (3) step();
    rst = 1'b0;
    check_wake("rst_wake");
    chk("rst_no_ack", 64'(ack_cnt[0] - acks0), 64'(0));
    chk("rst_rdata_kept0", 64'(rdata[0]), 64'(0));

    do_read(1'b1, 24'hFFFFFC, $urandom, 1'b0, 1'b0, "div1");
    do_read(1'b1, 24'($urandom), $urandom, 1'b0, 1'b1, "div1_rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
